rc4_key_search_ctrl: RTL and testbench

//  Top-level sequencer for the RC4 brute-force key search.
//  - Per candidate key: runs S-init, then KSA, then decrypt, each as a separate engine.
//  - Owns the select of the shared single-port S-RAM mux.
//  - Snoops decrypted-RAM writes and stops on the first key that yields all-printable plaintext.

---
 rtl/rc4_pkg.sv | 33 +++
 rtl/rc4_char_checker.sv | 34 +++
 rtl/rc4_key_search_ctrl.sv | 170 +++++++++++++++++
 tb/tb_rc4_key_search_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-search controller.
//  - rc4_state_t : sequencer states
//  - S_SEL_*     : S-RAM mux owner codes
//  - CHAR_*      : bounds of the accepted plaintext alphabet (space, 'a'..'z')
//  - is_print_char() : accepted-character test used by the checker
package rc4_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT_RUN,
      ST_INIT_RST,
      ST_KSA_RUN,
      ST_KSA_RST,
      ST_DEC_RUN,
      ST_DEC_RST,
      ST_NEXT_KEY,
      ST_DONE
   } rc4_state_t;

   localparam logic [1:0] S_SEL_NONE = 2'd0;
   localparam logic [1:0] S_SEL_INIT = 2'd1;
   localparam logic [1:0] S_SEL_KSA  = 2'd2;
   localparam logic [1:0] S_SEL_DEC  = 2'd3;

   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [7:0] CHAR_LO    = 8'h61;
   localparam logic [7:0] CHAR_HI    = 8'h7A;

   function automatic logic is_print_char(input logic [7:0] c);
      return (c == CHAR_SPACE) || ((c >= CHAR_LO) && (c <= CHAR_HI));
   endfunction

endpackage

// File: rtl/rc4_char_checker.sv
// Sticky plaintext validity flag.
// Ports:
//  clock  in   system clock
//  reset  in   asynchronous active-low reset
//  clr    in   synchronous clear of bad
//  en     in   snoop window (decrypt phase only)
//  wren   in   snooped D-RAM write strobe
//  data   in   snooped D-RAM write byte
//  bad    out  1 once any byte outside {space, 'a'..'z'} was written while en
module rc4_char_checker
   import rc4_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       clr,
   input  logic       en,
   input  logic       wren,
   input  logic [7:0] data,
   output logic       bad
);

   // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bad <= 1'b0;
      end else if (clr) begin
         bad <= 1'b0;
      end else if (en && wren && !is_print_char(data)) begin
         // Sticky: once a key is spoiled, later good bytes cannot rescue it.
         bad <= 1'b1;
      end
   end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Top-level sequencer for the RC4 brute-force key search.
// For each candidate key it runs S-init, KSA and decrypt in turn, owns the
// shared S-RAM mux select, snoops decrypted bytes and stops on the first key
// whose plaintext is entirely space / lowercase letters.
// Ports:
//  clock, reset               clock, async active-low reset
//  start                      1-cycle pulse, ignored while busy
//  init/ksa/dec_start         level, held until matching *_finish
//  init/ksa/dec_finish        engine done
//  eng_rst                    1-cycle restart to the engine that just stopped
//  s_sel                      S-RAM owner: 0 none, 1 init, 2 ksa, 3 dec
//  key_out                    current candidate key
//  dm_wren_in, dm_data_in     snooped decrypt writes
//  busy, done, found, key_found  search status / result
// Build option: define RC4_EARLY_ABORT_EN to abandon decrypt as soon as a bad
// byte is seen instead of waiting for dec_finish.
module rc4_key_search_ctrl
   import rc4_pkg::*;
#(
   parameter int               KEY_W     = 24,
   parameter logic [KEY_W-1:0] KEY_START = '0,
   parameter logic [KEY_W-1:0] KEY_END   = KEY_W'(24'h3FFFFF)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   output logic             init_start,
   input  logic             init_finish,
   output logic             ksa_start,
   input  logic             ksa_finish,
   output logic             dec_start,
   input  logic             dec_finish,
   output logic             eng_rst,
   output logic [1:0]       s_sel,
   output logic [KEY_W-1:0] key_out,
   input  logic             dm_wren_in,
   input  logic [7:0]       dm_data_in,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic [KEY_W-1:0] key_found
);

   rc4_state_t state;
   logic       bad;
   logic       bad_clr;
   logic       bad_en;

   // bad only changes in DEC_RUN, so clearing it in every quiet state is safe.
   assign bad_clr = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_NEXT_KEY);
   assign bad_en  = (state == ST_DEC_RUN);

   rc4_char_checker u_char_checker (
      .clock (clock),
      .reset (reset),
      .clr   (bad_clr),
      .en    (bad_en),
      .wren  (dm_wren_in),
      .data  (dm_data_in),
      .bad   (bad)
   );

   // Moore outputs are registered alongside the state: each transition
   // loads the outputs of the state being entered.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         init_start <= 1'b0;
         ksa_start  <= 1'b0;
         dec_start  <= 1'b0;
         eng_rst    <= 1'b0;
         s_sel      <= S_SEL_NONE;
         key_out    <= KEY_START;
         busy       <= 1'b0;
         done       <= 1'b0;
         found      <= 1'b0;
         key_found  <= '0;
      end else begin
         // Only the RST transitions raise eng_rst, giving a one-cycle pulse.
         eng_rst <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state      <= ST_INIT_RUN;
                  key_out    <= KEY_START;
                  done       <= 1'b0;
                  found      <= 1'b0;
                  key_found  <= '0;
                  busy       <= 1'b1;
                  init_start <= 1'b1;
                  s_sel      <= S_SEL_INIT;
               end
            end
            ST_INIT_RUN: begin
               if (init_finish) begin
                  state      <= ST_INIT_RST;
                  init_start <= 1'b0;
                  s_sel      <= S_SEL_NONE;
                  eng_rst    <= 1'b1;
               end
            end
            ST_INIT_RST: begin
               state     <= ST_KSA_RUN;
               ksa_start <= 1'b1;
               s_sel     <= S_SEL_KSA;
            end
            ST_KSA_RUN: begin
               if (ksa_finish) begin
                  state     <= ST_KSA_RST;
                  ksa_start <= 1'b0;
                  s_sel     <= S_SEL_NONE;
                  eng_rst   <= 1'b1;
               end
            end
            ST_KSA_RST: begin
               state     <= ST_DEC_RUN;
               dec_start <= 1'b1;
               s_sel     <= S_SEL_DEC;
            end
            ST_DEC_RUN: begin
`ifdef RC4_EARLY_ABORT_EN
               if (dec_finish || bad) begin
`else
               if (dec_finish) begin
`endif
                  state     <= ST_DEC_RST;
                  dec_start <= 1'b0;
                  s_sel     <= S_SEL_NONE;
                  eng_rst   <= 1'b1;
               end
            end
            ST_DEC_RST: begin
               // A bad byte written alongside dec_finish is already in bad here.
               if (!bad) begin
                  state     <= ST_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  found     <= 1'b1;
                  key_found <= key_out;
               end else begin
                  state <= ST_NEXT_KEY;
               end
            end
            ST_NEXT_KEY: begin
               if (key_out == KEY_END) begin
                  state     <= ST_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  found     <= 1'b0;
                  key_found <= '0;
               end else begin
                  state      <= ST_INIT_RUN;
                  key_out    <= key_out + KEY_W'(1);
                  init_start <= 1'b1;
                  s_sel      <= S_SEL_INIT;
               end
            end
            default: begin
               state      <= ST_IDLE;
               init_start <= 1'b0;
               ksa_start  <= 1'b0;
               dec_start  <= 1'b0;
               s_sel      <= S_SEL_NONE;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl with KEY_START=0, KEY_END=3.
// Engine models react to the start levels, the decrypt model writes a
// per-key message; the expected result is the first key whose message is
// all space / lowercase.
module tb_rc4_key_search_ctrl;

   localparam int KEY_W  = 24;
   localparam int N_KEYS = 4;
   localparam int MAX_LEN = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic             init_start, ksa_start, dec_start, eng_rst;
   logic             init_finish = 1'b0, ksa_finish = 1'b0, dec_finish = 1'b0;
   logic [1:0]       s_sel;
   logic [KEY_W-1:0] key_out, key_found;
   logic             dm_wren_in = 1'b0;
   logic [7:0]       dm_data_in = 8'h00;
   logic             busy, done, found;

   rc4_key_search_ctrl #(
      .KEY_W     (KEY_W),
      .KEY_START (24'h000000),
      .KEY_END   (24'h000003)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .init_start  (init_start),
      .init_finish (init_finish),
      .ksa_start   (ksa_start),
      .ksa_finish  (ksa_finish),
      .dec_start   (dec_start),
      .dec_finish  (dec_finish),
      .eng_rst     (eng_rst),
      .s_sel       (s_sel),
      .key_out     (key_out),
      .dm_wren_in  (dm_wren_in),
      .dm_data_in  (dm_data_in),
      .busy        (busy),
      .done        (done),
      .found       (found),
      .key_found   (key_found)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Stimulus / reference state
   logic [7:0] msg [N_KEYS][MAX_LEN];
   int         msg_len [N_KEYS];
   int         init_lat = 4;
   int         ksa_lat  = 4;
   bit         stray_en = 1'b0;
   int         seen [$];
   int         dec_max [N_KEYS];

   function automatic bit printable(input logic [7:0] b);
      return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
   endfunction

   function automatic bit all_print(input int k);
      for (int i = 0; i < msg_len[k]; i++)
         if (!printable(msg[k][i])) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [1:0] exp_sel(input logic i, input logic k, input logic d);
      if (i) return 2'd1;
      if (k) return 2'd2;
      if (d) return 2'd3;
      return 2'd0;
   endfunction

   // Bytes packed first-byte-in-MSB.
   task automatic load(input int k, input logic [63:0] bytes, input int len);
      logic [63:0] v;
      v = bytes;
      msg_len[k] = len;
      for (int i = 0; i < len; i++) msg[k][i] = v[8*(len-1-i) +: 8];
   endtask

   // Engine models plus per-cycle protocol monitor, all on the falling edge.
   initial begin : engines
      int  init_cnt, ksa_cnt, dec_cnt, cur_key;
      bit  init_sent, ksa_sent, dec_sent, acc_prev;
      init_cnt = 0; ksa_cnt = 0; dec_cnt = 0; cur_key = 0;
      init_sent = 0; ksa_sent = 0; dec_sent = 0; acc_prev = 0;
      forever begin
         @(negedge clock);
         if (reset) begin
            check("s_sel_map", 32'(s_sel), 32'(exp_sel(init_start, ksa_start, dec_start)));
            check("start_onehot", 32'($countones({init_start, ksa_start, dec_start}) <= 1), 1);
            if (acc_prev) check("eng_rst_after_finish", 32'(eng_rst), 1);
`ifndef RC4_EARLY_ABORT_EN
            else check("eng_rst_spurious", 32'(eng_rst), 0);
`endif
         end

         init_finish = 1'b0; ksa_finish = 1'b0; dec_finish = 1'b0;
         dm_wren_in = 1'b0; dm_data_in = 8'h00;
         if (!reset) begin
            init_cnt = 0; ksa_cnt = 0; dec_cnt = 0;
            init_sent = 0; ksa_sent = 0; dec_sent = 0;
         end else begin
            if (init_start) begin
               if (!init_sent) begin
                  init_cnt++;
                  if (init_cnt >= init_lat) begin init_finish = 1'b1; init_sent = 1; end
               end
            end else begin
               init_cnt = 0; init_sent = 0;
               if (stray_en && $urandom_range(0, 5) == 0) init_finish = 1'b1;
            end

            if (ksa_start) begin
               if (!ksa_sent) begin
                  ksa_cnt++;
                  if (ksa_cnt >= ksa_lat) begin ksa_finish = 1'b1; ksa_sent = 1; end
               end
            end else begin
               ksa_cnt = 0; ksa_sent = 0;
               if (stray_en && $urandom_range(0, 5) == 0) ksa_finish = 1'b1;
            end

            if (dec_start) begin
               if (dec_cnt == 0 && !dec_sent) begin
                  cur_key = int'(key_out[1:0]);
                  seen.push_back(int'(key_out));
               end
               if (!dec_sent) begin
                  dm_wren_in = 1'b1;
                  dm_data_in = msg[cur_key][dec_cnt];
                  dec_cnt++;
                  dec_max[cur_key] = dec_cnt;
                  if (dec_cnt >= msg_len[cur_key]) begin dec_finish = 1'b1; dec_sent = 1; end
               end
            end else begin
               dec_cnt = 0; dec_sent = 0;
               if (stray_en && $urandom_range(0, 3) == 0) begin
                  dm_wren_in = 1'b1;
                  dm_data_in = 8'(($urandom_range(0, 255)));
               end
               if (stray_en && $urandom_range(0, 5) == 0) dec_finish = 1'b1;
            end
         end
         acc_prev = reset && ((init_finish && init_start) || (ksa_finish && ksa_start) ||
                              (dec_finish && dec_start));
      end
   end

   task automatic run_search(input string tag, input bit poke_start);
      bit exp_found;
      int exp_key, exp_n;
      exp_found = 1'b0;
      exp_key   = 0;
      for (int k = 0; k < N_KEYS; k++)
         if (!exp_found && all_print(k)) begin exp_found = 1'b1; exp_key = k; end
      exp_n = exp_found ? exp_key + 1 : N_KEYS;
      seen.delete();
      for (int k = 0; k < N_KEYS; k++) dec_max[k] = 0;

      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
      if (poke_start) begin
         repeat ($urandom_range(1, 30)) @(negedge clock);
         if (busy) begin
            start = 1'b1;
            @(negedge clock); start = 1'b0;
         end
      end
      for (int i = 0; i < 4000 && !done; i++) @(negedge clock);

      check($sformatf("%s_done", tag), 32'(done), 1);
      check($sformatf("%s_busy", tag), 32'(busy), 0);
      check($sformatf("%s_found", tag), 32'(found), 32'(exp_found));
      check($sformatf("%s_key_found", tag), 32'(key_found), exp_found ? exp_key : 0);
      check($sformatf("%s_key_out", tag), 32'(key_out), exp_found ? exp_key : N_KEYS - 1);
      check($sformatf("%s_n_keys", tag), seen.size(), exp_n);
      for (int i = 0; i < seen.size() && i < exp_n; i++)
         check($sformatf("%s_key_seq%0d", tag, i), seen[i], i);
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      // Reset state, while held and just after release
      repeat (3) @(negedge clock);
      check("rst_init_start", 32'(init_start), 0);
      check("rst_ksa_start", 32'(ksa_start), 0);
      check("rst_dec_start", 32'(dec_start), 0);
      check("rst_eng_rst", 32'(eng_rst), 0);
      check("rst_s_sel", 32'(s_sel), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_found", 32'(found), 0);
      check("rst_key_out", 32'(key_out), 0);
      check("rst_key_found", 32'(key_found), 0);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      check("idle_busy", 32'(busy), 0);
      check("idle_done", 32'(done), 0);

      // Key 2 decrypts to "abc d", others to 'A'
      for (int k = 0; k < N_KEYS; k++) load(k, 64'h4141414141, 5);
      load(2, 64'h6162632064, 5);
      run_search("found2", 1'b0);

      // No key passes: 0x7B is just past 'z'
      for (int k = 0; k < N_KEYS; k++) load(k, 64'h7B7B7B7B, 4);
      run_search("none", 1'b0);

      // Bad byte on the same cycle as dec_finish still rejects the key
      load(0, 64'h61626341, 4);
      load(1, 64'h61626364, 4);
      run_search("bad_at_finish", 1'b0);

      // Reset during KSA of key 1 abandons the search immediately
      for (int k = 0; k < N_KEYS; k++) load(k, 64'h7B7B7B7B, 4);
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
      for (int i = 0; i < 500 && !(ksa_start && key_out == 1); i++) @(negedge clock);
      check("reach_ksa_key1", 32'(ksa_start && key_out == 1), 1);
      #2 reset = 1'b0;
      #1;
      check("arst_ksa_start", 32'(ksa_start), 0);
      check("arst_s_sel", 32'(s_sel), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_eng_rst", 32'(eng_rst), 0);
      check("arst_key_out", 32'(key_out), 0);
      check("arst_done", 32'(done), 0);
      @(negedge clock); @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("post_arst_busy", 32'(busy), 0);
      for (int k = 0; k < N_KEYS; k++) load(k, 64'h4141414141, 5);
      load(3, 64'h7A20617A, 4);
      run_search("after_reset", 1'b0);

      // Bad byte at the 2nd write of key 0
      load(0, 64'h6141626364, 5);
      load(1, 64'h6162636465, 5);
      run_search("abort", 1'b0);
`ifdef RC4_EARLY_ABORT_EN
      // bad registers on the 2nd write, DEC_RST follows a cycle later
      check("abort_dec_writes_key0", dec_max[0], 3);
`else
      check("abort_dec_writes_key0", dec_max[0], 5);
`endif

      // Randomized searches with stray strobes and start pulses while busy
      stray_en = 1'b1;
      for (int r = 0; r < 25; r++) begin
         init_lat = $urandom_range(1, 6);
         ksa_lat  = $urandom_range(1, 6);
         for (int k = 0; k < N_KEYS; k++) begin
            int r8;
            msg_len[k] = $urandom_range(1, 5);
            for (int i = 0; i < msg_len[k]; i++) begin
               if (i > 0 && $urandom_range(0, 3) == 0) begin
                  msg[k][i] = msg[k][i-1];
               end else begin
                  r8 = $urandom_range(0, 26);
                  msg[k][i] = (r8 == 26) ? 8'h20 : 8'(8'h61 + r8);
               end
            end
            if ($urandom_range(0, 2) != 0) begin
               logic [7:0] b;
               b = 8'(($urandom_range(0, 255)));
               while (printable(b)) b = 8'(($urandom_range(0, 255)));
               msg[k][$urandom_range(0, msg_len[k] - 1)] = b;
            end
         end
         run_search($sformatf("rand%0d", r), 1'b1);
      end
      stray_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
